// File: rtl/pipe_pkg.sv
// Shared types for the MEM/WB skid stage: the MEM->WB payload record and the
// occupancy states of the 2-entry skid buffer.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    typedef struct packed {
        logic                  RegWrite;
        logic                  MemtoReg;
        logic [REG_W_DEF-1:0]  WriteReg;
        logic [DATA_W_DEF-1:0] ReadData;
        logic [DATA_W_DEF-1:0] ALUOut;
    } mem_wb_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Packed width of a mem_wb_t-shaped record for arbitrary field widths.
    function automatic int payload_width(input int dataW, input int regW);
        return 2 + regW + 2 * dataW;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush; in_ready_o is
// decoded from the registered state only, so it never depends on out_ready_i.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    skid_state_t  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept;
    logic         fire;

    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = main_q;
    assign accept      = in_valid_i & in_ready_o;
    assign fire        = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = BUSY;
                    main_d  = in_data_i;
                end
            end
            BUSY: begin
                if (accept && !fire) begin
                    state_d = FULL;
                    skid_d  = in_data_i;
                end else if (accept && fire) begin
                    main_d  = in_data_i;
                end else if (fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (fire) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush only retires the occupancy; stale payload is masked by out_valid.
        if (flush_i) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM/WB boundary stage: skid-buffered payload, valid-qualified W outputs,
// a write-back forwarding tap for the hazard unit and a saturating stall counter.
module mem_wb_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic [REG_W-1:0]  WriteRegM,
    input  logic [DATA_W-1:0] ReadDataM,
    input  logic [DATA_W-1:0] ALUOutM,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic [REG_W-1:0]  WriteRegW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PW = payload_width(DATA_W, REG_W);

    typedef struct packed {
        logic              RegWrite;
        logic              MemtoReg;
        logic [REG_W-1:0]  WriteReg;
        logic [DATA_W-1:0] ReadData;
        logic [DATA_W-1:0] ALUOut;
    } entry_t;

    entry_t          inEntry;
    entry_t          mainEntry;
    logic [PW-1:0]   mainBits;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign inEntry = '{RegWrite: RegWriteM, MemtoReg: MemtoRegM, WriteReg: WriteRegM,
                       ReadData: ReadDataM, ALUOut: ALUOutM};

    pipe_skid_buf #(.W(PW)) u_skid (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (inEntry),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (mainBits)
    );

    assign mainEntry = entry_t'(mainBits);

    assign RegWriteW = mainEntry.RegWrite & out_valid;
    assign MemtoRegW = mainEntry.MemtoReg;
    assign WriteRegW = mainEntry.WriteReg;
    assign ReadDataW = mainEntry.ReadData;
    assign ALUOutW   = mainEntry.ALUOut;

    // r0 is hard-wired zero, so it is never offered as a forwarding source.
    assign fwd_valid = out_valid & mainEntry.RegWrite & (mainEntry.WriteReg != '0);
    assign fwd_reg   = mainEntry.WriteReg;
    assign fwd_data  = mainEntry.MemtoReg ? mainEntry.ReadData : mainEntry.ALUOut;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Self-checking bench for mem_wb_skid_stage: directed scenarios plus a random
// stream, checked against a queue-based model of a 2-deep FIFO stage.
module tb_mem_wb_skid_stage;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct packed {
        logic          rw;
        logic          mr;
        logic [RW-1:0] wr;
        logic [DW-1:0] rd;
        logic [DW-1:0] ao;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          RegWriteM;
    logic          MemtoRegM;
    logic [RW-1:0] WriteRegM;
    logic [DW-1:0] ReadDataM;
    logic [DW-1:0] ALUOutM;
    logic          out_valid;
    logic          out_ready;
    logic          RegWriteW;
    logic          MemtoRegW;
    logic [RW-1:0] WriteRegW;
    logic [DW-1:0] ReadDataW;
    logic [DW-1:0] ALUOutW;
    logic          fwd_valid;
    logic [RW-1:0] fwd_reg;
    logic [DW-1:0] fwd_data;
    logic [CW-1:0] stall_cnt;

    ent_t mq[$];
    ent_t sentList[$];
    ent_t recvList[$];
    int   modelCnt;
    int   total;
    int   bad;
    logic recording;
    logic obsValid;
    ent_t obsEnt;

    always #5 clk = ~clk;

    mem_wb_skid_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .RegWriteM (RegWriteM),
        .MemtoRegM (MemtoRegM),
        .WriteRegM (WriteRegM),
        .ReadDataM (ReadDataM),
        .ALUOutM   (ALUOutM),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .RegWriteW (RegWriteW),
        .MemtoRegW (MemtoRegW),
        .WriteRegW (WriteRegW),
        .ReadDataW (ReadDataW),
        .ALUOutW   (ALUOutW),
        .fwd_valid (fwd_valid),
        .fwd_reg   (fwd_reg),
        .fwd_data  (fwd_data),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model's view of the queue head.
    task automatic checkOutput();
        ent_t f;
        logic v;
        v = (mq.size() > 0);
        f = v ? mq[0] : '0;
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(v));
        chk("stall_cnt", 64'(stall_cnt), 64'(modelCnt));
        chk("RegWriteW", 64'(RegWriteW), 64'(v & f.rw));
        chk("fwd_valid", 64'(fwd_valid), 64'(v & f.rw & (f.wr != 0)));
        if (v) begin
            chk("MemtoRegW", 64'(MemtoRegW), 64'(f.mr));
            chk("WriteRegW", 64'(WriteRegW), 64'(f.wr));
            chk("ReadDataW", 64'(ReadDataW), 64'(f.rd));
            chk("ALUOutW", 64'(ALUOutW), 64'(f.ao));
            chk("fwd_reg", 64'(fwd_reg), 64'(f.wr));
            chk("fwd_data", 64'(fwd_data), 64'(f.mr ? f.rd : f.ao));
        end
        obsValid = out_valid;
        obsEnt   = '{rw: RegWriteW, mr: MemtoRegW, wr: WriteRegW, rd: ReadDataW, ao: ALUOutW};
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
    task automatic applyStimulus(input logic iv, input ent_t e, input logic ordy, input logic fl);
        logic acc;
        ent_t d;
        in_valid  = iv;
        {RegWriteM, MemtoRegM, WriteRegM, ReadDataM, ALUOutM} = e;
        out_ready = ordy;
        flush     = fl;
        if (recording && obsValid && ordy && !fl) recvList.push_back(obsEnt);
        acc = iv && (mq.size() < 2);
        @(posedge clk);
        if ((mq.size() > 0) && !ordy && (modelCnt < CNT_MAX)) modelCnt++;
        if (fl) begin
            mq.delete();
        end else begin
            if ((mq.size() > 0) && ordy) d = mq.pop_front();
            if (acc) begin
                mq.push_back(e);
                if (recording) sentList.push_back(e);
            end
        end
        @(negedge clk);
        checkOutput();
    endtask

    function automatic ent_t mk(input logic rw, input logic mr, input logic [RW-1:0] wr,
                                input logic [DW-1:0] rd, input logic [DW-1:0] ao);
        return '{rw: rw, mr: mr, wr: wr, rd: rd, ao: ao};
    endfunction

    initial begin
        ent_t a, b, c, r;
        int   n;
        total = 0;
        bad = 0;
        modelCnt = 0;
        recording = 1'b0;
        obsValid = 1'b0;
        obsEnt = '0;
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        {RegWriteM, MemtoRegM, WriteRegM, ReadDataM, ALUOutM} = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput();
        chk("rst_ALUOutW", 64'(ALUOutW), 64'd0);
        chk("rst_WriteRegW", 64'(WriteRegW), 64'd0);
        chk("rst_fwd_data", 64'(fwd_data), 64'd0);
        chk("rst_fwd_reg", 64'(fwd_reg), 64'd0);
        @(negedge clk);

        // Single entry through an empty stage.
        applyStimulus(1'b1, mk(1'b1, 1'b0, 5'd5, 32'h0, 32'h11), 1'b1, 1'b0);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_wreg", 64'(WriteRegW), 64'd5);
        chk("t1_alu", 64'(ALUOutW), 64'h11);
        chk("t1_fwd_valid", 64'(fwd_valid), 64'd1);
        chk("t1_fwd_data", 64'(fwd_data), 64'h11);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Back-pressure fills the skid, then drains in order.
        a = mk(1'b1, 1'b0, 5'd7, 32'hA0A0, 32'hAAAA);
        b = mk(1'b1, 1'b1, 5'd9, 32'hBBBB, 32'hB0B0);
        applyStimulus(1'b1, a, 1'b0, 1'b0);
        applyStimulus(1'b1, b, 1'b0, 1'b0);
        chk("t2_full_in_ready", 64'(in_ready), 64'd0);
        chk("t2_full_shows_a", 64'(ALUOutW), 64'hAAAA);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        chk("t2_shows_b", 64'(ALUOutW), 64'hB0B0);
        chk("t2_in_ready_back", 64'(in_ready), 64'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        chk("t2_empty", 64'(out_valid), 64'd0);

        // Flush from FULL discards both held entries and the one presented with it.
        c = mk(1'b1, 1'b0, 5'd3, 32'hCCCC, 32'hC0C0);
        applyStimulus(1'b1, a, 1'b0, 1'b0);
        applyStimulus(1'b1, b, 1'b0, 1'b0);
        applyStimulus(1'b1, c, 1'b0, 1'b1);
        chk("t3_flush_valid", 64'(out_valid), 64'd0);
        chk("t3_flush_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Register 0 writes back but is never forwarded.
        applyStimulus(1'b1, mk(1'b1, 1'b1, 5'd0, 32'hAB, 32'h55), 1'b0, 1'b0);
        chk("t4_fwd_valid", 64'(fwd_valid), 64'd0);
        chk("t4_regwrite", 64'(RegWriteW), 64'd1);
        chk("t4_fwd_data", 64'(fwd_data), 64'hAB);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Random stream scoreboarded against the accepted sequence.
        recording = 1'b1;
        n = 0;
        while ((n < 3000) && (sentList.size() < 100)) begin
            r = mk(1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom);
            applyStimulus(1'($urandom_range(0, 1)), r, ($urandom_range(0, 9) < 6), 1'b0);
            n++;
        end
        chk("rand_sent_100", 64'(sentList.size() >= 100), 64'd1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        recording = 1'b0;
        chk("sb_count", 64'(recvList.size()), 64'(sentList.size()));
        for (int i = 0; i < sentList.size() && i < recvList.size(); i++) begin
            chk($sformatf("sb_entry%0d", i), 64'(recvList[i].ao ^ recvList[i].rd ^ 32'(recvList[i].wr)),
                64'(sentList[i].ao ^ sentList[i].rd ^ 32'(sentList[i].wr)));
            chk($sformatf("sb_ctl%0d", i), 64'({recvList[i].rw, recvList[i].mr}),
                64'({sentList[i].rw, sentList[i].mr}));
        end

        // Fresh reset, then saturate the stall counter.
        reset = 1'b1;
        mq.delete();
        modelCnt = 0;
        @(negedge clk);
        reset = 1'b0;
        checkOutput();
        applyStimulus(1'b1, mk(1'b1, 1'b0, 5'd12, 32'h1, 32'h2), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        chk("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));
        chk("stall_hold_alu", 64'(ALUOutW), 64'h2);

        // Asynchronous reset between clock edges.
        #2;
        reset = 1'b1;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("async_in_ready", 64'(in_ready), 64'd1);
        mq.delete();
        modelCnt = 0;
        @(negedge clk);
        reset = 1'b0;
        checkOutput();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
